mic1_uart_mmio: RTL and testbench
=================================

Name: mic1_uart_mmio

Overview:
- Memory-mapped UART I/O bridge between the mic1 data port and the existing uart_rx/uart_tx serialisers.
- Generalises the single-byte receive register and tx_busy run-gating into parametrised RX/TX FIFOs, a status register, a sticky overrun flag and a per-access stall.
- Sits in mic1_soc beside main_memory. The SoC muxes bus_rdata when hit=1 and gates mic1 run with stall.

Parameters:
- DATA_ADDR, 32'hFFFFFFFD: RX pop / TX push address.
- STATUS_ADDR, 32'hFFFFFFFC: status/control address.
- RX_DEPTH, 16: RX FIFO entries; power of 2, at least 2.
- TX_DEPTH, 16: TX FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- bus_addr  in  32  mic1 data address.
- bus_read  in  1  read strobe, already qualified with run.
- bus_write  in  1  write strobe, already qualified with run.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  read data, combinational.
- hit  out  1  bus_addr equals DATA_ADDR or STATUS_ADDR.
- stall  out  1  access cannot complete this cycle.
- rx_done  in  1  one-cycle pulse from uart_rx.
- rx_data  in  8  received byte.
- tx_start  out  1  one-cycle start pulse to uart_tx.
- tx_data  out  8  byte to uart_tx, held until the next start.
- tx_busy  in  1  uart_tx busy.

Behaviour:
- Reset values: both FIFOs empty, pointers 0, overrun 0, tx_start 0, tx_data 0, tx_gap 0. Combinational outputs then read hit=0 (for a non-matching address), stall=0, bus_rdata=0.
- FIFO pointers are log2(DEPTH)+1 bits wide and wrap naturally. Full when the MSBs differ and the remaining bits are equal; empty when the pointers are equal. Counts are wp - rp, range 0..DEPTH.
- DATA read (bus_read and addr==DATA_ADDR):
  - bus_rdata = {24'h0, RX head}.
  - If RX is non-empty, pop on the clock edge.
  - If RX is empty, return 0 and pop nothing. This never stalls, so software polling for 0 still works.
- DATA write (bus_write and addr==DATA_ADDR):
  - If TX is not full, push bus_wdata[7:0] on the edge; stall=0.
  - If TX is full, stall=1 combinationally and no push. The mic1 holds the strobe and the push completes on the first cycle a slot frees.
- STATUS read returns:
  - [0] rx_valid (RX non-empty)
  - [1] rx_full
  - [2] tx_full
  - [3] tx_idle (TX empty, !tx_busy, !tx_start, !tx_gap)
  - [4] overrun
  - [15:8] rx_count, zero-extended
  - [23:16] tx_count, zero-extended
  - all other bits 0
  - Has no side effects.
- STATUS write: bus_wdata[4]=1 clears overrun. All other bits are ignored.
- Any access to a non-matching address: hit=0, stall=0, bus_rdata=0, no state change.
- RX push: on rx_done, push rx_data if RX is not full.
  - rx_done with RX full: byte dropped, overrun set. Overrun is sticky until cleared.
  - rx_done and a DATA pop in the same cycle with RX full: both occur, byte kept, no overrun.
  - Overrun set and a STATUS clear in the same cycle: set wins.
- TX drain, registered:
  - Condition: TX non-empty, !tx_busy, !tx_start, !tx_gap.
  - When it holds, tx_start<=1 for exactly one cycle, tx_data<=TX head, and TX pops on the same edge.
  - tx_gap<=1 for the cycle after tx_start. This covers uart_tx's one-cycle busy latency, so no two starts occur within 2 cycles.
- Simultaneous CPU push and drain pop: both occur, count unchanged. A push into a full FIFO in the same cycle as a drain pop is still stalled, because stall is evaluated on the current full flag.
- Reset mid-operation: both FIFOs are flushed immediately. tx_start is deasserted immediately; a byte already serialising in uart_tx is that block's concern. Strobes during rst are ignored.

Test Plan:
- Reset then idle: STATUS read = 32'h0000_0008; DATA read = 0; tx_start never pulses.
- RX ordering: rx_done with 8'h33, 8'h34, 8'h0A → STATUS[15:8]=3; three DATA reads return 33, 34, 0A; a fourth read returns 0 and STATUS bit0=0.
- RX overflow: 17 rx_done pulses with RX_DEPTH=16 → overrun=1, 17th byte lost; STATUS write 32'h10 → bit4=0. Repeat with a DATA pop coincident with the 17th pulse → no overrun, 16 bytes held.
- TX burst: 3 DATA writes (41, 42, 43) on consecutive cycles with tx_busy low → no stall; tx_start pulses carry 41, 42, 43 in order, at least 2 cycles apart, each only after tx_busy falls.
- TX full stall: hold tx_busy=1 and write 17 bytes → the 17th write sees stall=1 for consecutive cycles; release tx_busy → stall drops the cycle after the drain pop and byte 17 is enqueued last.
- Async reset mid-burst: assert rst with both FIFOs half full → counts 0 and tx_start=0 within the same cycle; STATUS = 32'h0000_0008 after release.

Source files
------------

// File: rtl/mic1_uart_mmio.sv
// mic1_uart_mmio: memory-mapped bridge between the mic1 data port and the
// uart_rx / uart_tx serialisers. It holds received bytes in an RX FIFO and
// queues bytes for transmit in a TX FIFO. It also provides a status register,
// a sticky RX overrun flag and a stall for writes into a full TX FIFO.
//
// Ports
//   clk, rst             system clock, asynchronous active-high reset
//   bus_addr/read/write  mic1 data port strobes (already qualified with run)
//   bus_wdata            write data; only [7:0] reaches the TX FIFO
//   bus_rdata            combinational read data (0 unless a mapped read)
//   hit                  bus_addr decodes to DATA_ADDR or STATUS_ADDR
//   stall                DATA write into a full TX FIFO; the mic1 holds the strobe
//   rx_done, rx_data     byte-received pulse and byte from uart_rx
//   tx_start, tx_data    one-cycle start pulse and held byte to uart_tx
//   tx_busy              uart_tx is serialising
module mic1_uart_mmio #(
  parameter logic [31:0] DATA_ADDR   = 32'hFFFF_FFFD,
  parameter logic [31:0] STATUS_ADDR = 32'hFFFF_FFFC,
  parameter int          RX_DEPTH    = 16,
  parameter int          TX_DEPTH    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic        bus_read,
  input  logic        bus_write,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        hit,
  output logic        stall,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy
);

  localparam int RXA = $clog2(RX_DEPTH);
  localparam int RXW = RXA + 1;
  localparam int TXA = $clog2(TX_DEPTH);
  localparam int TXW = TXA + 1;

  // Storage is read asynchronously: the DATA read returns the RX head in the
  // same cycle as the strobe, so a registered-read RAM cannot be used here.
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [RXW-1:0] rx_wp_reg, rx_rp_reg;
  logic [TXW-1:0] tx_wp_reg, tx_rp_reg;
  logic           overrun_reg;
  logic           tx_start_reg;
  logic           tx_gap_reg;
  logic [7:0]     tx_data_reg;

  logic           data_sel, status_sel;
  logic           rx_empty, rx_full, tx_empty, tx_full;
  logic [RXW-1:0] rx_count;
  logic [TXW-1:0] tx_count;
  logic [7:0]     rx_head, tx_head;
  logic           rx_pop, rx_push, overrun_set, overrun_clr;
  logic           tx_push, tx_drain, tx_idle;
  logic [31:0]    status_word;

  assign data_sel   = (bus_addr == DATA_ADDR);
  assign status_sel = (bus_addr == STATUS_ADDR);
  assign hit        = data_sel | status_sel;

  // Pointers carry one extra wrap bit so full and empty can be distinguished.
  assign rx_empty = (rx_wp_reg == rx_rp_reg);
  assign rx_full  = (rx_wp_reg[RXA] != rx_rp_reg[RXA]) &&
                    (rx_wp_reg[RXA-1:0] == rx_rp_reg[RXA-1:0]);
  assign tx_empty = (tx_wp_reg == tx_rp_reg);
  assign tx_full  = (tx_wp_reg[TXA] != tx_rp_reg[TXA]) &&
                    (tx_wp_reg[TXA-1:0] == tx_rp_reg[TXA-1:0]);
  assign rx_count = rx_wp_reg - rx_rp_reg;
  assign tx_count = tx_wp_reg - tx_rp_reg;
  assign rx_head  = rx_mem[rx_rp_reg[RXA-1:0]];
  assign tx_head  = tx_mem[tx_rp_reg[TXA-1:0]];

  // A pop in the same cycle frees a slot, so a byte arriving at a full FIFO
  // is still kept.
  assign rx_pop      = bus_read & data_sel & ~rx_empty;
  assign rx_push     = rx_done & (~rx_full | rx_pop);
  assign overrun_set = rx_done & rx_full & ~rx_pop;
  assign overrun_clr = bus_write & status_sel & bus_wdata[4];

  // Stall uses the current full flag only; a same-cycle drain pop does not
  // let the held write through until the following cycle.
  assign tx_push  = bus_write & data_sel & ~tx_full;
  assign stall    = bus_write & data_sel & tx_full;
  // tx_gap covers the cycle before uart_tx raises tx_busy after a start.
  assign tx_drain = ~tx_empty & ~tx_busy & ~tx_start_reg & ~tx_gap_reg;
  assign tx_idle  = tx_empty & ~tx_busy & ~tx_start_reg & ~tx_gap_reg;

  assign status_word = {8'h00, 8'(tx_count), 8'(rx_count), 3'b000,
                        overrun_reg, tx_idle, tx_full, rx_full, ~rx_empty};

  always_comb begin
    bus_rdata = 32'h0;
    if (bus_read && data_sel && !rx_empty) begin
      bus_rdata = {24'h0, rx_head};
    end else if (bus_read && status_sel) begin
      bus_rdata = status_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wp_reg[RXA-1:0]] <= rx_data;
    end
    if (tx_push) begin
      tx_mem[tx_wp_reg[TXA-1:0]] <= bus_wdata[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wp_reg    <= '0;
      rx_rp_reg    <= '0;
      tx_wp_reg    <= '0;
      tx_rp_reg    <= '0;
      overrun_reg  <= 1'b0;
      tx_start_reg <= 1'b0;
      tx_gap_reg   <= 1'b0;
      tx_data_reg  <= 8'h00;
    end else begin
      if (rx_push) rx_wp_reg <= rx_wp_reg + RXW'(1);
      if (rx_pop)  rx_rp_reg <= rx_rp_reg + RXW'(1);
      if (tx_push) tx_wp_reg <= tx_wp_reg + TXW'(1);
      if (tx_drain) begin
        tx_rp_reg   <= tx_rp_reg + TXW'(1);
        tx_data_reg <= tx_head;
      end
      tx_start_reg <= tx_drain;
      tx_gap_reg   <= tx_start_reg;
      // A new overrun in the same cycle as a clear takes precedence.
      if (overrun_set) begin
        overrun_reg <= 1'b1;
      end else if (overrun_clr) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign tx_start = tx_start_reg;
  assign tx_data  = tx_data_reg;

endmodule

// File: tb/tb_mic1_uart_mmio.sv
// tb_mic1_uart_mmio: scoreboard bench for mic1_uart_mmio. Stimulus tasks
// update a queue-based reference model and push expected read data / TX bytes.
// A monitor on the falling edge pops and compares whenever the DUT presents a
// read or a tx_start. A small uart_tx stand-in drives tx_busy.
module tb_mic1_uart_mmio;
  localparam logic [31:0] DA = 32'hFFFF_FFFD;
  localparam logic [31:0] SA = 32'hFFFF_FFFC;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bus_addr = 32'h0;
  logic        bus_read = 1'b0;
  logic        bus_write = 1'b0;
  logic [31:0] bus_wdata = 32'h0;
  logic [31:0] bus_rdata;
  logic        hit, stall;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        hold_busy = 1'b0;
  logic        busy_sim = 1'b0;

  assign tx_busy = hold_busy | busy_sim;

  mic1_uart_mmio dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_read(bus_read),
    .bus_write(bus_write), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .hit(hit), .stall(stall), .rx_done(rx_done), .rx_data(rx_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: FIFO contents as queues, overrun as a bit.
  logic [7:0] rx_q[$];
  logic [7:0] tx_exp_q[$];
  logic       ovr_m = 1'b0;

  typedef struct {
    logic [31:0] exp;
    logic [31:0] mask;
  } rd_t;
  rd_t rd_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h @%0d", name, act, exp, cyc);
    end else begin
      $display("pass %s 0x%08h @%0d", name, act, cyc);
    end
  endtask

  function automatic logic [31:0] status_model();
    int rn = rx_q.size();
    int tn = tx_exp_q.size();
    logic [31:0] s = 32'h0;
    s[0] = (rn != 0);
    s[1] = (rn == DEPTH);
    s[2] = (tn == DEPTH);
    s[3] = (tn == 0) && !tx_busy;
    s[4] = ovr_m;
    s[15:8] = 8'(rn);
    s[23:16] = 8'(tn);
    return s;
  endfunction

  task automatic rx_byte(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
    else ovr_m = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  // DATA read, optionally with a coincident rx_done (pop happens first).
  task automatic data_read(input bit with_rx, input logic [7:0] b);
    rd_t r;
    bus_addr = DA;
    bus_read = 1'b1;
    r.exp = (rx_q.size() > 0) ? {24'h0, rx_q.pop_front()} : 32'h0;
    r.mask = 32'hFFFF_FFFF;
    rd_q.push_back(r);
    if (with_rx) begin
      rx_done = 1'b1;
      rx_data = b;
      if (rx_q.size() < DEPTH) rx_q.push_back(b);
      else ovr_m = 1'b1;
    end
    @(posedge clk); #1;
    bus_read = 1'b0;
    rx_done = 1'b0;
  endtask

  task automatic status_read(input logic [31:0] mask);
    rd_t r;
    bus_addr = SA;
    bus_read = 1'b1;
    r.exp = status_model();
    r.mask = mask;
    rd_q.push_back(r);
    @(posedge clk); #1;
    bus_read = 1'b0;
  endtask

  task automatic status_write(input logic [31:0] v);
    bus_addr = SA;
    bus_write = 1'b1;
    bus_wdata = v;
    if (v[4]) ovr_m = 1'b0;
    @(posedge clk); #1;
    bus_write = 1'b0;
  endtask

  task automatic data_write(input logic [7:0] b, output int stalls);
    bit done = 0;
    stalls = 0;
    bus_addr = DA;
    bus_write = 1'b1;
    bus_wdata = {$urandom_range(0, 16777215), b};
    while (!done) begin
      @(negedge clk);
      if (!stall) begin
        done = 1;
        tx_exp_q.push_back(b);
      end else begin
        stalls++;
        if (stalls > 500) begin
          chk("tx_write_timeout", {31'h0, stall}, 32'h0);
          done = 1;
        end
      end
      @(posedge clk); #1;
    end
    bus_write = 1'b0;
  endtask

  task automatic nomatch_access(input bit is_write);
    logic [31:0] a = $urandom;
    if (a == DA || a == SA) a = 32'h0000_1000;
    bus_addr = a;
    bus_wdata = 32'h0000_0010;
    if (is_write) bus_write = 1'b1;
    else bus_read = 1'b1;
    @(negedge clk);
    chk("nomatch_rdata", bus_rdata, 32'h0);
    chk("nomatch_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    bus_write = 1'b0;
    bus_read = 1'b0;
  endtask

  task automatic wait_tx_drain();
    int n = 0;
    while (tx_exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("tx_drain_left", tx_exp_q.size(), 32'h0);
    repeat (10) @(posedge clk);
    #1;
  endtask

  // uart_tx stand-in: busy rises the cycle after tx_start, for 1..6 cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin
        @(posedge clk); #1;
        busy_sim = 1'b1;
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1;
        busy_sim = 1'b0;
      end
    end
  end

  // Monitor: compare every mapped read and every tx_start against the model.
  int last_start = -100;
  logic prev_busy = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus_read || bus_write)
          chk("hit", {31'h0, hit}, {31'h0, (bus_addr == DA) || (bus_addr == SA)});
        if (bus_read && (bus_addr == DA || bus_addr == SA)) begin
          if (rd_q.size() == 0) begin
            chk("rd_unexpected", {31'h0, bus_read}, 32'h0);
          end else begin
            rd_t r = rd_q.pop_front();
            chk((bus_addr == DA) ? "data_rd" : "status_rd", bus_rdata & r.mask, r.exp & r.mask);
          end
        end
        if (tx_start) begin
          if (tx_exp_q.size() == 0) begin
            chk("tx_unexpected", {31'h0, tx_start}, 32'h0);
          end else begin
            chk("tx_byte", {24'h0, tx_data}, {24'h0, tx_exp_q.pop_front()});
          end
          chk("tx_spacing", {31'h0, (cyc - last_start) >= 2}, 32'h1);
          chk("tx_busy_low", {31'h0, prev_busy}, 32'h0);
          last_start = cyc;
        end
      end
      prev_busy = tx_busy;
    end
  end

  initial begin
    int st;
    logic [7:0] b17;
    int n;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_stall", {31'h0, stall}, 32'h0);
    chk("reset_rdata", bus_rdata, 32'h0);
    chk("reset_tx_start", {31'h0, tx_start}, 32'h0);
    @(posedge clk); #1;
    status_read(32'hFFFF_FFFF);
    data_read(0, 8'h0);
    nomatch_access(0);
    nomatch_access(1);
    repeat (20) @(posedge clk);
    #1;

    // RX ordering
    rx_byte(8'h33);
    rx_byte(8'h34);
    rx_byte(8'h0A);
    status_read(32'hFFFF_FFFF);
    repeat (4) data_read(0, 8'h0);
    status_read(32'hFFFF_FFFF);

    // RX overflow, then overflow avoided by a coincident pop
    repeat (17) rx_byte(8'($urandom));
    status_read(32'hFFFF_FFFF);
    status_write(32'h0000_0010);
    status_read(32'hFFFF_FFFF);
    repeat (16) data_read(0, 8'h0);
    repeat (16) rx_byte(8'($urandom));
    data_read(1, 8'hC5);
    status_read(32'hFFFF_FFFF);
    repeat (16) data_read(0, 8'h0);
    status_read(32'hFFFF_FFFF);

    // TX burst on consecutive cycles
    data_write(8'h41, st); chk("burst_stall0", st, 32'h0);
    data_write(8'h42, st); chk("burst_stall1", st, 32'h0);
    data_write(8'h43, st); chk("burst_stall2", st, 32'h0);
    wait_tx_drain();
    status_read(32'hFFFF_FFFF);

    // TX full stall
    hold_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      data_write(8'(8'h50 + i), st);
      chk("fill_stall", st, 32'h0);
    end
    status_read(32'hFFFF_FFFF);
    b17 = 8'hEE;
    bus_addr = DA;
    bus_write = 1'b1;
    bus_wdata = {24'h0, b17};
    repeat (4) begin
      @(negedge clk);
      chk("full_stall", {31'h0, stall}, 32'h1);
      @(posedge clk); #1;
    end
    hold_busy = 1'b0;
    @(negedge clk);
    chk("stall_before_pop", {31'h0, stall}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_after_pop", {31'h0, stall}, 32'h0);
    tx_exp_q.push_back(b17);
    @(posedge clk); #1;
    bus_write = 1'b0;
    wait_tx_drain();

    // Randomized mix
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 10))
        0, 1, 2: rx_byte(8'($urandom));
        3, 4:    data_read(0, 8'h0);
        5:       data_read(1, 8'($urandom));
        6, 7:    data_write(8'($urandom), st);
        8:       status_read(32'h0000_FF13);
        9:       status_write($urandom);
        default: nomatch_access(1'($urandom));
      endcase
    end
    while (rx_q.size() != 0) data_read(0, 8'h0);
    wait_tx_drain();
    status_write(32'h0000_0010);
    status_read(32'hFFFF_FFFF);

    // Asynchronous reset mid-burst
    hold_busy = 1'b1;
    for (int i = 0; i < 8; i++) data_write(8'(8'hA0 + i), st);
    for (int i = 0; i < 8; i++) rx_byte(8'(8'h70 + i));
    hold_busy = 1'b0;
    n = 0;
    @(negedge clk);
    while (!tx_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_start_seen", {31'h0, tx_start}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_tx_start", {31'h0, tx_start}, 32'h0);
    bus_addr = SA;
    bus_read = 1'b1;
    #1;
    chk("rst_counts", {16'h0, bus_rdata[23:8]}, 32'h0);
    bus_read = 1'b0;
    rx_q.delete();
    tx_exp_q.delete();
    rd_q.delete();
    ovr_m = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    status_read(32'hFFFF_FFFF);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1);
  end
endmodule
